// File: rtl/video_pixel_fetcher.sv
// Fetches framebuffer words from video RAM and shifts them out MSB-first as the pixel stream.
// Optional line doubling (each memory row shown on two lines): define VIDEO_PIXEL_FETCHER_LINE_DOUBLE_EN.
module video_pixel_fetcher #(
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned LINES          = 200,
    parameter int unsigned ADDRESS_WIDTH  = 12
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_start,
    input  logic                     line_start,
    input  logic                     pixel_strobe,
    output logic                     mem_read,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic                     mem_ready,
    input  logic [WORD_WIDTH-1:0]    mem_data,
    output logic                     pixel,
    output logic                     underrun
);
    localparam int unsigned LINE_W = $clog2(LINES + 1);
    localparam int unsigned WCNT_W = $clog2(WORDS_PER_LINE + 1);
    localparam int unsigned PIXELS = WORDS_PER_LINE * WORD_WIDTH;
    localparam int unsigned PCNT_W = $clog2(PIXELS + 1);
    localparam int unsigned BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] FETCH      = 3'd1;
    localparam logic [2:0] ACTIVE     = 3'd2;
    localparam logic [2:0] LINE_DONE  = 3'd3;
    localparam logic [2:0] FRAME_DONE = 3'd4;

    logic [2:0]               state, state_next;
    logic                     armed, armed_next;
    logic [LINE_W-1:0]        line_index, line_index_next;
    logic [WCNT_W-1:0]        words_fetched, words_fetched_next;
    logic [PCNT_W-1:0]        pixel_count, pixel_count_next;
    logic [BIT_W-1:0]         bit_index, bit_index_next;
    logic [WORD_WIDTH-1:0]    shift_reg, shift_reg_next;
    logic [WORD_WIDTH-1:0]    prefetch_reg, prefetch_reg_next;
    logic                     shift_valid, shift_valid_next;
    logic                     prefetch_valid, prefetch_valid_next;
    logic                     mem_read_next;
    logic [ADDRESS_WIDTH-1:0] mem_address_next;
    logic                     pixel_next;
    logic                     underrun_next;
    logic                     capture;
    logic                     line_go;
    logic [LINE_W-1:0]        line_target;

    // First word address of the memory row shown on a given display line
    function automatic logic [ADDRESS_WIDTH-1:0] row_base(input logic [LINE_W-1:0] line);
`ifdef VIDEO_PIXEL_FETCHER_LINE_DOUBLE_EN
        return ADDRESS_WIDTH'(32'(line >> 1) * WORDS_PER_LINE);
`else
        return ADDRESS_WIDTH'(32'(line) * WORDS_PER_LINE);
`endif
    endfunction

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            armed          <= 1'b0;
            line_index     <= '0;
            words_fetched  <= '0;
            pixel_count    <= '0;
            bit_index      <= '0;
            shift_reg      <= '0;
            prefetch_reg   <= '0;
            shift_valid    <= 1'b0;
            prefetch_valid <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            pixel          <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            state          <= state_next;
            armed          <= armed_next;
            line_index     <= line_index_next;
            words_fetched  <= words_fetched_next;
            pixel_count    <= pixel_count_next;
            bit_index      <= bit_index_next;
            shift_reg      <= shift_reg_next;
            prefetch_reg   <= prefetch_reg_next;
            shift_valid    <= shift_valid_next;
            prefetch_valid <= prefetch_valid_next;
            mem_read       <= mem_read_next;
            mem_address    <= mem_address_next;
            pixel          <= pixel_next;
            underrun       <= underrun_next;
        end
    end

    // Next-state, fetch and shift logic
    always_comb begin
        state_next          = state;
        armed_next          = armed;
        line_index_next     = line_index;
        words_fetched_next  = words_fetched;
        pixel_count_next    = pixel_count;
        bit_index_next      = bit_index;
        shift_reg_next      = shift_reg;
        prefetch_reg_next   = prefetch_reg;
        shift_valid_next    = shift_valid;
        prefetch_valid_next = prefetch_valid;
        mem_address_next    = mem_address;
        pixel_next          = pixel;
        underrun_next       = underrun;
        mem_read_next       = 1'b0;
        capture             = mem_read && mem_ready;
        line_go             = 1'b0;
        line_target         = line_index;

        if (frame_start) begin
            state_next          = IDLE;
            armed_next          = 1'b1;
            line_index_next     = '0;
            words_fetched_next  = '0;
            pixel_count_next    = '0;
            bit_index_next      = '0;
            shift_valid_next    = 1'b0;
            prefetch_valid_next = 1'b0;
            mem_address_next    = '0;
            pixel_next          = 1'b0;
            underrun_next       = 1'b0;
            if (line_start) begin
                line_go     = 1'b1;
                line_target = '0;
            end
        end else if (line_start && (state == FETCH || state == ACTIVE || state == LINE_DONE)) begin
            // An early line_start truncates the current line and moves on like a normal one
            line_go     = 1'b1;
            line_target = line_index + LINE_W'(1);
        end else if (line_start && state == IDLE && armed) begin
            line_go     = 1'b1;
            line_target = line_index;
        end else begin
            case (state)
                FETCH: state_next = ACTIVE;
                ACTIVE: begin
                    if (pixel_strobe) begin
                        if (shift_valid) begin
                            pixel_next = shift_reg[WORD_WIDTH-1];
                        end else begin
                            pixel_next    = 1'b0;
                            underrun_next = 1'b1;
                        end
                        shift_reg_next = shift_reg << 1;
                        if (bit_index == BIT_W'(WORD_WIDTH - 1)) begin
                            bit_index_next      = '0;
                            shift_reg_next      = prefetch_reg;
                            shift_valid_next    = prefetch_valid;
                            prefetch_valid_next = 1'b0;
                        end else begin
                            bit_index_next = bit_index + BIT_W'(1);
                        end
                        pixel_count_next = pixel_count + PCNT_W'(1);
                        if (pixel_count == PCNT_W'(PIXELS - 1)) begin
                            state_next = LINE_DONE;
                        end
                    end
                end
                IDLE, LINE_DONE, FRAME_DONE: pixel_next = 1'b0;
                default: state_next = IDLE;
            endcase

            // Accepted read lands in the shifter if it is empty, otherwise in the prefetch slot
            if ((state == FETCH || state == ACTIVE) && capture) begin
                if (!shift_valid_next) begin
                    shift_reg_next   = mem_data;
                    shift_valid_next = 1'b1;
                end else begin
                    prefetch_reg_next   = mem_data;
                    prefetch_valid_next = 1'b1;
                end
                words_fetched_next = words_fetched + WCNT_W'(1);
                mem_address_next   = mem_address + ADDRESS_WIDTH'(1);
            end
        end

        if (line_go) begin
            line_index_next     = line_target;
            words_fetched_next  = '0;
            pixel_count_next    = '0;
            bit_index_next      = '0;
            shift_valid_next    = 1'b0;
            prefetch_valid_next = 1'b0;
            pixel_next          = 1'b0;
            if (line_target == LINE_W'(LINES)) begin
                state_next = FRAME_DONE;
            end else begin
                state_next       = FETCH;
                mem_address_next = row_base(line_target);
            end
        end

        mem_read_next = (state_next == FETCH || state_next == ACTIVE) && !prefetch_valid_next &&
                        (words_fetched_next < WCNT_W'(WORDS_PER_LINE));
    end

endmodule

// File: tb/tb_video_pixel_fetcher.sv
// Directed self-checking bench for video_pixel_fetcher with a variable-latency memory model.
// Expected addresses follow the row mapping selected by VIDEO_PIXEL_FETCHER_LINE_DOUBLE_EN.
module tb_video_pixel_fetcher;
    localparam int unsigned WW  = 16;
    localparam int unsigned WPL = 16;
    localparam int unsigned AW  = 12;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          frame_start;
    logic          line_start;
    logic          pixel_strobe;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic          mem_ready;
    logic [WW-1:0] mem_data;
    logic          pixel;
    logic          underrun;

    int            mem_lat;
    int            wait_cnt;
    logic [AW-1:0] cap_log [0:2047];
    int            cap_total;
    int            mark;
    int            checks;
    int            errors;

    video_pixel_fetcher #(
        .WORD_WIDTH    (WW),
        .WORDS_PER_LINE(WPL),
        .LINES         (200),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .line_start  (line_start),
        .pixel_strobe(pixel_strobe),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .pixel       (pixel),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    // Memory: ready after mem_lat waiting cycles, data is a fixed function of the address
    assign mem_ready = mem_read && (wait_cnt >= mem_lat);
    assign mem_data  = 16'hA5A5 ^ WW'(mem_address);

    always @(posedge clock) begin
        if (!mem_read || mem_ready) wait_cnt <= 0;
        else                        wait_cnt <= wait_cnt + 1;
        if (reset_n && mem_read && mem_ready && cap_total < 2048) begin
            cap_log[cap_total] <= mem_address;
            cap_total          <= cap_total + 1;
        end
    end

    function automatic int exp_base(input int line);
`ifdef VIDEO_PIXEL_FETCHER_LINE_DOUBLE_EN
        return (line >> 1) * WPL;
`else
        return line * WPL;
`endif
    endfunction

    function automatic logic exp_pixel(input int base, input int j);
        logic [15:0] w;
        w = 16'hA5A5 ^ 16'(base + j / 16);
        return w[15 - (j % 16)];
    endfunction

    function automatic logic [31:0] cap_at(input int idx);
        if (idx < cap_total) return 32'(cap_log[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe_check(input string tag, input int base, input int j);
        pixel_strobe = 1'b1;
        tick(1);
        pixel_strobe = 1'b0;
        check_value(tag, 32'(pixel), 32'(exp_pixel(base, j)));
    endtask

    task automatic pulse_line;
        line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; mark = 0;
        reset_n = 1'b0; frame_start = 1'b1; line_start = 1'b0; pixel_strobe = 1'b0; mem_lat = 1;
        tick(2);
        check_value("rst_pixel", 32'(pixel), 0);
        check_value("rst_read", 32'(mem_read), 0);
        check_value("rst_addr", 32'(mem_address), 0);
        check_value("rst_underrun", 32'(underrun), 0);
        reset_n = 1'b1; frame_start = 1'b0;

        // line_start before any frame_start is ignored
        pulse_line();
        tick(2);
        check_value("idle_no_read", 32'(mem_read), 0);

        // Basic line 0, slow strobes
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        pulse_line();
        mark = cap_total;
        tick(8);
        for (int j = 0; j < 256; j++) begin
            strobe_check("basic_pixel", exp_base(0), j);
            tick(6);
        end
        tick(2);
        check_value("basic_end_pixel", 32'(pixel), 0);
        check_value("basic_end_read", 32'(mem_read), 0);
        check_value("basic_underrun", 32'(underrun), 0);
        check_value("basic_cap_count", 32'(cap_total - mark), 16);
        for (int i = 0; i < 16; i++) check_value("basic_addr", cap_at(mark + i), 32'(exp_base(0) + i));

        // Underrun on line 1: slow memory, strobes every cycle
        mem_lat = 40;
        pulse_line();
        pixel_strobe = 1'b1;
        tick(4);
        check_value("urun_pixel", 32'(pixel), 0);
        check_value("urun_flag", 32'(underrun), 1);
        tick(296);
        pixel_strobe = 1'b0;
        tick(2);
        check_value("urun_end_pixel", 32'(pixel), 0);
        check_value("urun_end_read", 32'(mem_read), 0);
        check_value("urun_sticky", 32'(underrun), 1);

        // frame_start clears underrun
        mem_lat = 1;
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        check_value("frame_clr_underrun", 32'(underrun), 0);
        check_value("frame_drop_read", 32'(mem_read), 0);

        // Lines 0..2 truncated quickly, then line 3 with a pending read at truncation
        for (int k = 0; k < 3; k++) begin
            pulse_line();
            tick(3);
        end
        mem_lat = 20;
        pulse_line();
        tick(50);
        for (int j = 0; j < 40; j++) begin
            strobe_check("line3_pixel", exp_base(3), j);
            tick(1);
        end
        pulse_line();
        mark = cap_total;
        check_value("trunc_pixel", 32'(pixel), 0);
        check_value("trunc_read", 32'(mem_read), 1);
        check_value("trunc_addr", 32'(mem_address), 32'(exp_base(4)));
        tick(50);
        check_value("trunc_first_cap", cap_at(mark), 32'(exp_base(4)));
        check_value("trunc_second_cap", cap_at(mark + 1), 32'(exp_base(4) + 1));
        for (int j = 0; j < 16; j++) begin
            strobe_check("line4_pixel", exp_base(4), j);
            tick(1);
        end

        // Run through to line 199 and display it completely
        mem_lat = 1;
        for (int k = 5; k < 199; k++) begin
            pulse_line();
            tick(3);
        end
        pulse_line();
        mark = cap_total;
        tick(8);
        pixel_strobe = 1'b1;
        tick(260);
        pixel_strobe = 1'b0;
        tick(2);
        check_value("l199_end_pixel", 32'(pixel), 0);
        check_value("l199_end_read", 32'(mem_read), 0);
        check_value("l199_cap_count", 32'(cap_total - mark), 16);
        for (int i = 0; i < 16; i++) check_value("l199_addr", cap_at(mark + i), 32'(exp_base(199) + i));

        // 201st line_start ends the frame; further line_starts and strobes are ignored
        pulse_line();
        for (int k = 0; k < 5; k++) begin
            check_value("fdone_no_read", 32'(mem_read), 0);
            tick(1);
        end
        pulse_line();
        pixel_strobe = 1'b1; tick(3); pixel_strobe = 1'b0;
        check_value("fdone_ignore_read", 32'(mem_read), 0);
        check_value("fdone_pixel", 32'(pixel), 0);

        // frame_start together with line_start starts line 0 at once
        frame_start = 1'b1; line_start = 1'b1; tick(1); frame_start = 1'b0; line_start = 1'b0;
        mark = cap_total;
        check_value("restart_read", 32'(mem_read), 1);
        check_value("restart_addr", 32'(mem_address), 0);
        tick(3);
        check_value("restart_cap", cap_at(mark), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
